// File: rtl/ice_cream_pkg.sv
// Shared encodings for the ice-cream vendor: coin codes, FSM states and coin valuation.
package ice_cream_pkg;

  typedef enum logic [1:0] {
    COIN0        = 2'b00,
    COIN1        = 2'b01,
    COIN2        = 2'b10,
    COIN_INVALID = 2'b11
  } coin_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CREDIT   = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3
  } state_e;

  function automatic logic [1:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ice_cream_rise_edge_det.sv
// Registered rising-edge detector; history resets high so a level held through reset is not an edge.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic ev
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b1;
      ev   <= 1'b0;
    end else begin
      prev <= d;
      ev   <= d & ~prev;
    end
  end

endmodule

// File: rtl/ice_cream_vendor_param.sv
// Parametrised Moore ice-cream vendor: coin credit, vend/dispense FSM, optional change return.
// Optional feature: define CHANGE_RETURN_EN to return the post-vend remainder through the CHANGE state.
module ice_cream_vendor_param
  import ice_cream_pkg::*;
#(
  parameter int CREDIT_W        = 4,
  parameter int BALL_PRICE      = 2,
  parameter int MAX_BALLS       = 3,
  parameter int BALLS_W         = 2,
  parameter int DISPENSE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                insert,
  input  logic [1:0]          coins,
  input  logic                vend,
  output logic [BALLS_W-1:0]  ice_cream_balls,
  output logic [2:0]          state,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid
);

  localparam int CW    = CREDIT_W + 1;
  localparam int CMAX  = 2**CREDIT_W - 1;
  localparam int CNT_W = $clog2(DISPENSE_CYCLES + 1);

  state_e            st;
  logic [CNT_W-1:0]  cnt;
  logic              ins_ev, vend_ev;
  logic [1:0]        v;
  logic [CW-1:0]     sum, eff, n_full, n_sel;
  logic [CREDIT_W-1:0] rem;
  logic              coin_ok, coin_bad;

  rise_edge_det u_ins_edge  (.clk(clk), .reset(reset), .d(insert), .ev(ins_ev));
  rise_edge_det u_vend_edge (.clk(clk), .reset(reset), .d(vend),   .ev(vend_ev));

  assign state = st;

  // eff folds a same-cycle accepted coin into the credit seen by a vend request.
  always_comb begin
    v        = coin_value(coins);
    sum      = {1'b0, credit} + CW'(v);
    coin_ok  = ins_ev && (coins == COIN1 || coins == COIN2) && (sum <= CW'(CMAX));
    coin_bad = ins_ev && (coins != COIN0) && !coin_ok;
    eff      = coin_ok ? sum : {1'b0, credit};
    n_full   = eff / CW'(BALL_PRICE);
    n_sel    = (n_full > CW'(MAX_BALLS)) ? CW'(MAX_BALLS) : n_full;
    rem      = CREDIT_W'(eff - n_sel * CW'(BALL_PRICE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st              <= IDLE;
      credit          <= '0;
      ice_cream_balls <= '0;
      cnt             <= '0;
      coin_reject     <= 1'b0;
`ifdef CHANGE_RETURN_EN
      change          <= '0;
      change_valid    <= 1'b0;
`endif
    end else begin
      coin_reject <= 1'b0;
`ifdef CHANGE_RETURN_EN
      change       <= '0;
      change_valid <= 1'b0;
`endif
      case (st)
        IDLE: begin
          coin_reject <= coin_bad;
          if (coin_ok) begin
            credit <= sum[CREDIT_W-1:0];
            st     <= CREDIT;
          end
        end
        CREDIT: begin
          coin_reject <= coin_bad;
          if (vend_ev && eff >= CW'(BALL_PRICE)) begin
            credit          <= rem;
            ice_cream_balls <= BALLS_W'(n_sel);
            cnt             <= '0;
            st              <= DISPENSE;
          end else begin
            credit <= eff[CREDIT_W-1:0];
          end
        end
        DISPENSE: begin
          coin_reject <= ins_ev;
          if (cnt == CNT_W'(DISPENSE_CYCLES - 1)) begin
            ice_cream_balls <= '0;
            cnt             <= '0;
`ifdef CHANGE_RETURN_EN
            if (credit != '0) begin
              // change is presented while the FSM sits in CHANGE
              change       <= credit;
              change_valid <= 1'b1;
              st           <= CHANGE;
            end else begin
              st <= IDLE;
            end
`else
            st <= (credit != '0) ? CREDIT : IDLE;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHANGE: begin
          coin_reject <= ins_ev;
          credit      <= '0;
          st          <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifndef CHANGE_RETURN_EN
  assign change       = '0;
  assign change_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ice_cream_vendor_param.sv
// Directed bench for ice_cream_vendor_param: vector table plus overflow, change and async-reset sequences.
module tb_ice_cream_vendor_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       insert;
  logic [1:0] coins;
  logic       vend;
  logic [1:0] ice_cream_balls;
  logic [2:0] state;
  logic [3:0] credit;
  logic       coin_reject;
  logic [3:0] change;
  logic       change_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  ice_cream_vendor_param dut (
    .clk(clk), .reset(reset), .insert(insert), .coins(coins), .vend(vend),
    .ice_cream_balls(ice_cream_balls), .state(state), .credit(credit),
    .coin_reject(coin_reject), .change(change), .change_valid(change_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ins;
    logic [1:0] coins;
    logic       vend;
    logic [2:0] st;
    logic [3:0] cr;
    logic [1:0] balls;
    logic       rej;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input logic i, input logic [1:0] c, input logic vd);
    insert = i; coins = c; vend = vd;
    @(posedge clk); #1;
  endtask

  task automatic coin(input logic [1:0] c);
    step(1'b1, c, 1'b0);
    step(1'b0, c, 1'b0);
  endtask

  task automatic do_reset();
    insert = 1'b0; coins = 2'b00; vend = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    //            ins coins vend  st cr balls rej
    tbl[0]  = '{1'b0, 2'b00, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'b10, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'b10, 1'b0, 3'd1, 4'd2, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 2'b10, 1'b0, 3'd1, 4'd2, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 3'd1, 4'd4, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 1'b0, 3'd1, 4'd4, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 3'd1, 4'd5, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 1'b1, 3'd1, 4'd5, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 2'b10, 1'b0, 3'd2, 4'd1, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 3'd2, 4'd1, 2'd2, 1'b1};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 3'd1, 4'd1, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b1, 3'd1, 4'd1, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 3'd1, 4'd1, 2'd0, 1'b0};
    tbl[13] = '{1'b1, 2'b11, 1'b0, 3'd1, 4'd1, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 2'b11, 1'b0, 3'd1, 4'd1, 2'd0, 1'b1};
    tbl[15] = '{1'b0, 2'b00, 1'b0, 3'd1, 4'd1, 2'd0, 1'b0};
    tbl[16] = '{1'b1, 2'b01, 1'b1, 3'd1, 4'd1, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 2'b01, 1'b0, 3'd2, 4'd0, 2'd1, 1'b0};
    tbl[18] = '{1'b0, 2'b00, 1'b0, 3'd2, 4'd0, 2'd1, 1'b0};
    tbl[19] = '{1'b0, 2'b00, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};

    insert = 1'b0; coins = 2'b00; vend = 1'b0; reset = 1'b0;
    #2;
    check("reset_state",  state, 3'd0);
    check("reset_credit", credit, 4'd0);
    check("reset_balls",  ice_cream_balls, 2'd0);
    check("reset_reject", coin_reject, 1'b0);
    check("reset_chgv",   change_valid, 1'b0);
    do_reset();

`ifndef CHANGE_RETURN_EN
    // Remainder carried as credit: dispense, reject-in-dispense, low-credit vend, bad coin, coin+vend.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].ins, tbl[i].coins, tbl[i].vend);
      check($sformatf("vec%0d_state", i),  state, tbl[i].st);
      check($sformatf("vec%0d_credit", i), credit, tbl[i].cr);
      check($sformatf("vec%0d_balls", i),  ice_cream_balls, tbl[i].balls);
      check($sformatf("vec%0d_reject", i), coin_reject, tbl[i].rej);
      check($sformatf("vec%0d_chgv", i),   change_valid, 1'b0);
    end
`else
    // 10,10,01 then vend: two balls, change of one.
    coin(2'b10); coin(2'b10); coin(2'b01);
    check("chg_pre_credit", credit, 4'd5);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    check("chg_balls0", ice_cream_balls, 2'd2);
    step(1'b0, 2'b00, 1'b0);
    check("chg_balls1", ice_cream_balls, 2'd2);
    step(1'b0, 2'b00, 1'b0);
    check("chg_state",  state, 3'd3);
    check("chg_valid",  change_valid, 1'b1);
    check("chg_amount", change, 4'd1);
    check("chg_balls2", ice_cream_balls, 2'd0);
    step(1'b0, 2'b00, 1'b0);
    check("chg_idle",   state, 3'd0);
    check("chg_credit", credit, 4'd0);
    check("chg_vdrop",  change_valid, 1'b0);
`endif

    // Credit saturation: seven 2-unit coins reach 14, the eighth is refused.
    do_reset();
    for (int i = 0; i < 7; i++) coin(2'b10);
    check("ovf_credit14", credit, 4'd14);
    check("ovf_state",    state, 3'd1);
    coin(2'b10);
    check("ovf_reject",   coin_reject, 1'b1);
    check("ovf_credit",   credit, 4'd14);
    step(1'b0, 2'b00, 1'b1);
    check("ovf_rej_drop", coin_reject, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    check("ovf_balls0",   ice_cream_balls, 2'd3);
    check("ovf_credit8",  credit, 4'd8);
    check("ovf_dstate",   state, 3'd2);
    step(1'b0, 2'b00, 1'b0);
    check("ovf_balls1",   ice_cream_balls, 2'd3);
    step(1'b0, 2'b00, 1'b0);
    check("ovf_balls_end", ice_cream_balls, 2'd0);
`ifdef CHANGE_RETURN_EN
    check("ovf_exit_state", state, 3'd3);
    check("ovf_change",     change, 4'd8);
    check("ovf_change_v",   change_valid, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    check("ovf_idle",       state, 3'd0);
    check("ovf_cleared",    credit, 4'd0);
`else
    check("ovf_exit_state", state, 3'd1);
    check("ovf_keep_credit", credit, 4'd8);
`endif

    // Asynchronous reset mid-dispense, insert held high across release.
    do_reset();
    coin(2'b10);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    check("ar_dispensing", state, 3'd2);
    check("ar_balls_pre",  ice_cream_balls, 2'd1);
    insert = 1'b1; coins = 2'b10;
    #2 reset = 1'b0;
    #1;
    check("ar_balls",  ice_cream_balls, 2'd0);
    check("ar_state",  state, 3'd0);
    check("ar_credit", credit, 4'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("ar_rel%0d_credit", i), credit, 4'd0);
      check($sformatf("ar_rel%0d_state", i),  state, 3'd0);
      check($sformatf("ar_rel%0d_reject", i), coin_reject, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
